// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB fade sequencer: colour struct,
// sequencer state encoding and the fixed 8-entry palette.
package rgb_seq_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        SEQ_FADE = 1'b0,
        SEQ_HOLD = 1'b1
    } seq_state_e;

    localparam int PALETTE_SIZE = 8;

    // Walk order: red, green, blue, yellow, cyan, magenta, white, black.
    localparam rgb_t PALETTE [PALETTE_SIZE] = '{
        24'hFF0000,
        24'h00FF00,
        24'h0000FF,
        24'hFFFF00,
        24'h00FFFF,
        24'hFF00FF,
        24'hFFFFFF,
        24'h000000
    };

endpackage

// File: rtl/step_tick_gen.sv
// Fade-step prescaler: divides clk by DIV and emits a one-cycle tick on the
// last count. The count freezes (and no tick is produced) while enable is low,
// so the tick phase resumes exactly where it stopped.
module step_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int                CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] pre_cnt;

    // Prescaler counter: 0..DIV-1 then wrap, only while enabled.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (enable) begin
            if (pre_cnt == CNT_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    assign tick = enable && (pre_cnt == CNT_LAST);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB status-LED colour sequencer. Fades the three duty channels one LSB per
// step tick toward the current target, holds there for HOLD_STEPS ticks, then
// moves on to the next palette entry. A host override can replace the target
// at any time without advancing the palette index.
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int STEP_HZ    = 1000,
    parameter int HOLD_STEPS = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        ovr_valid,
    input  logic [23:0] ovr_rgb,
    output logic        ovr_ready,
    output logic [7:0]  duty_r,
    output logic [7:0]  duty_g,
    output logic [7:0]  duty_b,
    output logic        busy,
    output logic [2:0]  color_idx
);

    localparam int                DIV       = CLK_HZ / STEP_HZ;
    localparam int                HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    localparam logic [0:0] FADE = 1'(SEQ_FADE);
    localparam logic [0:0] HOLD = 1'(SEQ_HOLD);

    // Reject parameter sets the prescaler and hold counter cannot honour.
    if (DIV < 2) begin : g_div_check
        $error("rgb_fade_sequencer: CLK_HZ/STEP_HZ must be at least 2");
    end
    if (HOLD_STEPS < 1) begin : g_hold_check
        $error("rgb_fade_sequencer: HOLD_STEPS must be at least 1");
    end

    logic              step_tick;
    logic [0:0]        state;
    rgb_t              target;
    rgb_t              duty;
    rgb_t              duty_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        idx;
    logic [2:0]        idx_next;
    logic              ovr_fire;
    logic              all_at_target;
    logic              hold_done;

    // One LSB toward the target; a channel already at target stays put.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

    step_tick_gen #(
        .DIV (DIV)
    ) u_step_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (step_tick)
    );

    // Overrides are accepted whenever the sequencer is running, in either state.
    // NOTE: ovr_ready is purely combinational from enable, so the host sees it in the same cycle.
    assign ovr_ready = enable;
    assign ovr_fire  = ovr_valid & enable;

    // Three identical compare/inc/dec slices, one per channel.
    assign duty_next.r = step_toward(duty.r, target.r);
    assign duty_next.g = step_toward(duty.g, target.g);
    assign duty_next.b = step_toward(duty.b, target.b);

    assign all_at_target = (duty_next == target);
    assign hold_done     = (hold_cnt == HOLD_LAST);
    assign idx_next      = idx + 3'd1;

    // Duty registers: step on every FADE tick. The step always uses the target
    // as it stood before this edge, so an override accepted on a tick only
    // takes effect from the following tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= '0;
        end else if (step_tick && (state == FADE)) begin
            duty <= duty_next;
        end
    end

    // Sequencer FSM: target selection, hold timing and palette advance.
    // An override takes priority over a hold expiry on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FADE;
            target   <= PALETTE[0];
            hold_cnt <= '0;
            idx      <= '0;
        end else if (ovr_fire) begin
            target   <= ovr_rgb;
            state    <= FADE;
            hold_cnt <= '0;
        end else if (step_tick) begin
            if (state == FADE) begin
                if (all_at_target) begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end
            end else begin
                if (hold_done) begin
                    idx      <= idx_next;
                    target   <= PALETTE[idx_next];
                    state    <= FADE;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    assign duty_r    = duty.r;
    assign duty_g    = duty.g;
    assign duty_b    = duty.b;
    assign busy      = (state == FADE);
    assign color_idx = idx;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with DIV=10, HOLD_STEPS=4.
// Expected output snapshots {color_idx, busy, R, G, B} are queued when a step
// is set up and popped when the DUT is sampled on the falling clock edge.
// Cycle numbers count rising edges since the last reset release.
module tb_rgb_fade_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        ovr_valid;
    logic [23:0] ovr_rgb;
    logic        ovr_ready;
    logic [7:0]  duty_r;
    logic [7:0]  duty_g;
    logic [7:0]  duty_b;
    logic        busy;
    logic [2:0]  color_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    rgb_fade_sequencer #(
        .CLK_HZ     (100),
        .STEP_HZ    (10),
        .HOLD_STEPS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ovr_valid (ovr_valid),
        .ovr_rgb   (ovr_rgb),
        .ovr_ready (ovr_ready),
        .duty_r    (duty_r),
        .duty_g    (duty_g),
        .duty_b    (duty_b),
        .busy      (busy),
        .color_idx (color_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] observed();
        return {4'd0, color_idx, busy, duty_r, duty_g, duty_b};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic expect_state(input string tag, input logic [2:0] idx,
                                input logic b, input logic [23:0] rgb);
        expect_val(tag, {4'd0, idx, b, rgb});
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp_v;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
            return;
        end
        tag   = tag_q.pop_front();
        exp_v = exp_q.pop_front();
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic state_at(input int c, input string tag, input logic [2:0] idx,
                            input logic b, input logic [23:0] rgb);
        expect_state(tag, idx, b, rgb);
        goto(c);
        check(observed());
    endtask

    task automatic pulse_override(input logic [23:0] rgb);
        ovr_valid = 1'b1;
        ovr_rgb   = rgb;
        goto(cyc + 1);
        ovr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        ovr_valid = 1'b0;
        ovr_rgb   = 24'h0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        enable    = 1'b0;
        ovr_valid = 1'b0;
        ovr_rgb   = 24'h0;
        repeat (2) @(negedge clk);
        expect_val("rst_ovr_ready", 32'd0);
        check({31'd0, ovr_ready});
        expect_state("rst_outputs", 3'd0, 1'b1, 24'h000000);
        check(observed());

        // ---------------- first fade, hold, second fade ----------------
        rst_n  = 1'b1;
        enable = 1'b1;
        cyc    = 0;
        #1;
        expect_val("en_ovr_ready", 32'd1);
        check({31'd0, ovr_ready});
        state_at(9,    "a_pre_tick",    3'd0, 1'b1, 24'h000000);
        state_at(10,   "a_first_tick",  3'd0, 1'b1, 24'h010000);
        state_at(2549, "a_r254",        3'd0, 1'b1, 24'hFE0000);
        state_at(2550, "a_r255_hold",   3'd0, 1'b0, 24'hFF0000);
        state_at(2589, "a_hold_last",   3'd0, 1'b0, 24'hFF0000);
        state_at(2590, "a_idx1",        3'd1, 1'b1, 24'hFF0000);
        state_at(2600, "a_crossfade",   3'd1, 1'b1, 24'hFE0100);
        state_at(3360, "a_g77",         3'd1, 1'b1, 24'hB24D00);

        // ---------------- async reset mid-fade ----------------
        rst_n = 1'b0;
        #1;
        expect_state("async_reset", 3'd0, 1'b1, 24'h000000);
        check(observed());
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        state_at(10,    "r_restart",   3'd0, 1'b1, 24'h010000);

        // ---------------- palette walk and wrap ----------------
        state_at(5180,  "w_idx2",      3'd2, 1'b1, 24'h00FF00);
        state_at(18130, "w_idx7",      3'd7, 1'b1, 24'hFFFFFF);
        state_at(20680, "w_black",     3'd7, 1'b0, 24'h000000);
        state_at(20719, "w_hold_last", 3'd7, 1'b0, 24'h000000);
        state_at(20720, "w_wrap",      3'd0, 1'b1, 24'h000000);
        state_at(20730, "w_red_again", 3'd0, 1'b1, 24'h010000);

        // ---------------- override mid-fade at R=100 ----------------
        do_reset();
        state_at(1000, "o_r100",      3'd0, 1'b1, 24'h640000);
        expect_state("o_accept", 3'd0, 1'b1, 24'h640000);
        pulse_override(24'h102030);
        check(observed());
        state_at(1010, "o_first",     3'd0, 1'b1, 24'h630101);
        state_at(1839, "o_prelast",   3'd0, 1'b1, 24'h112030);
        state_at(1840, "o_reached",   3'd0, 1'b0, 24'h102030);
        state_at(1879, "o_hold_last", 3'd0, 1'b0, 24'h102030);
        state_at(1880, "o_resume",    3'd1, 1'b1, 24'h102030);
        state_at(1890, "o_to_green",  3'd1, 1'b1, 24'h0F212F);

        // ---------------- override on hold-expiry tick ----------------
        do_reset();
        state_at(2589, "h_hold_last", 3'd0, 1'b0, 24'hFF0000);
        expect_state("h_ovr_wins", 3'd0, 1'b1, 24'hFF0000);
        pulse_override(24'h102030);
        check(observed());
        state_at(2600, "h_first",     3'd0, 1'b1, 24'hFE0101);
        state_at(4979, "h_prelast",   3'd0, 1'b1, 24'h112030);
        state_at(4980, "h_reached",   3'd0, 1'b0, 24'h102030);
        state_at(5019, "h_hold_last", 3'd0, 1'b0, 24'h102030);
        state_at(5020, "h_idx1",      3'd1, 1'b1, 24'h102030);

        // ---------------- override on a FADE tick, then equal to duty ----------------
        do_reset();
        state_at(49,  "t_r4",        3'd0, 1'b1, 24'h040000);
        expect_state("t_old_target_step", 3'd0, 1'b1, 24'h050000);
        pulse_override(24'h000000);
        check(observed());
        state_at(60,  "t_new_target", 3'd0, 1'b1, 24'h040000);
        state_at(99,  "t_r1",         3'd0, 1'b1, 24'h010000);
        state_at(100, "t_black_hold", 3'd0, 1'b0, 24'h000000);
        goto(114);
        expect_state("e_same_accept", 3'd0, 1'b1, 24'h000000);
        pulse_override(24'h000000);
        check(observed());
        state_at(119, "e_pre_tick",   3'd0, 1'b1, 24'h000000);
        state_at(120, "e_hold",       3'd0, 1'b0, 24'h000000);
        state_at(159, "e_hold_last",  3'd0, 1'b0, 24'h000000);
        state_at(160, "e_idx1",       3'd1, 1'b1, 24'h000000);
        state_at(170, "e_to_green",   3'd1, 1'b1, 24'h000100);

        // ---------------- enable low for 37 cycles mid-fade ----------------
        do_reset();
        state_at(23, "f_r2", 3'd0, 1'b1, 24'h020000);
        enable    = 1'b0;
        ovr_valid = 1'b1;
        ovr_rgb   = 24'h00FF00;
        #1;
        expect_val("f_ovr_ready_low", 32'd0);
        check({31'd0, ovr_ready});
        state_at(60, "f_frozen", 3'd0, 1'b1, 24'h020000);
        enable    = 1'b1;
        ovr_valid = 1'b0;
        state_at(66, "f_phase_kept", 3'd0, 1'b1, 24'h020000);
        state_at(67, "f_resumed",    3'd0, 1'b1, 24'h030000);
        state_at(77, "f_next_tick",  3'd0, 1'b1, 24'h040000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Colour sequencer for the board's RGB status LED. It walks an 8-entry palette, fading each channel linearly toward the next colour and holding there for a fixed time. It produces three 8-bit duty values that feed the RGB PWM generator, which then drives the active-low LED pins. A host-side override port can redirect the fade to an arbitrary colour at any time.

## Interface

Parameters:

- `CLK_HZ`, default 100_000_000: input clock frequency (board oscillator).
- `STEP_HZ`, default 1000: fade step rate. `DIV = CLK_HZ/STEP_HZ` and must be ≥ 2 (elaboration-time check).
- `HOLD_STEPS`, default 500: step ticks spent holding at each target. Must be ≥ 1.

Ports:

- `clk`  in  1: system clock. Single clock domain.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: 0 freezes the sequencer; all registers hold.
- `ovr_valid`  in  1: override request.
- `ovr_rgb`  in  24: override colour, packed {R[23:16], G[15:8], B[7:0]}.
- `ovr_ready`  out  1: override can be accepted this cycle.
- `duty_r`, `duty_g`, `duty_b`  out  8 each: PWM duty, 0 = off, 255 = full.
- `busy`  out  1: 1 while in FADE.
- `color_idx`  out  3: current palette index.

## Operation

Prescaler:

- `pre_cnt` counts 0..DIV-1 while `enable`=1, then wraps to 0.
- `step_tick` is a 1-cycle pulse when `pre_cnt` = DIV-1.

States: FADE, HOLD.

- **FADE:** on each `step_tick`, each channel independently moves 1 LSB toward its target.
  - Channels already at target do not move.
  - On the first tick where all three channels equal the target after the update, go to HOLD and clear `hold_cnt`.
  - If current already equals target on entry, the next tick moves to HOLD with no duty change.
- **HOLD:** `hold_cnt` increments on each `step_tick`.
  - On the tick where `hold_cnt` = HOLD_STEPS-1: `color_idx` ← `color_idx`+1, wrapping 7→0.
  - On the same tick: target ← `PALETTE[new idx]`, state → FADE.

Override:

- `ovr_ready` = `enable`, in both states.
- On `ovr_valid & ovr_ready`: target ← `ovr_rgb`, state → FADE, `hold_cnt` cleared, `color_idx` unchanged.
- After the override colour has been held, the sequence resumes at `color_idx`+1.

Boundary rules:

- Override accepted in the same cycle as a hold-expiry tick: override wins and `color_idx` does not advance.
- Override accepted on a FADE tick: that tick's duty step is still applied toward the *old* target; the new target applies from the next tick.
- Override equal to the current duty: one tick later, enter HOLD.
- `enable`=0: prescaler, counters, state and duty are frozen. `ovr_ready`=0.
- `rst_n` low mid-fade: every register returns to its reset value immediately (asynchronous). No partial state survives.

Reset values:

- `duty_r`/`g`/`b` = 0.
- `color_idx` = 0.
- target = `PALETTE[0]`.
- state = FADE.
- `pre_cnt` = 0, `hold_cnt` = 0.
- `busy` = 1 (the state is FADE).
- `ovr_ready` follows `enable`.

## Timing

- All outputs are registered except `ovr_ready`, which is combinational from `enable`.
- Duty values change in the cycle after `step_tick`.
- First tick occurs DIV cycles after `rst_n` deasserts with `enable`=1.
- A full 0→255 channel swing takes 255 ticks.
- Fade length is max |Δchannel| ticks. The HOLD→FADE transition adds no extra tick.
- Override latency: target is updated 1 cycle after acceptance. The first step toward it happens on the next tick.
- Width: `hold_cnt` is `$clog2(HOLD_STEPS)` bits, minimum 1. `pre_cnt` is `$clog2(DIV)` bits.

## Structure

- Package `rgb_seq_pkg` contains:
  - `typedef rgb_t`: struct of three 8-bit fields.
  - `PALETTE[8]` constants: FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, FFFFFF, 000000.
  - The state enum.
- Sub-module `step_tick_gen` (param DIV; ports `clk`, `rst_n`, `enable`, `tick`) holds the prescaler.
- The FSM and the per-channel step logic live in the top module. The step logic is three identical compare/inc/dec slices.

## Test plan

Sim parameters: CLK_HZ=100, STEP_HZ=10 (DIV=10), HOLD_STEPS=4.

1. Reset then `enable`=1.
   - `duty_r` reaches 255 after 255 ticks (cycle 2550 + 1). G and B stay 0.
   - HOLD lasts 4 ticks, then `color_idx`=1.
   - R ramps down while G ramps up over 255 ticks.
2. Override `ovr_rgb`=0x102030 during the first fade, at `duty_r`=100.
   - R decrements to 0x10. G and B increment to 0x20 and 0x30.
   - HOLD, then resume at `color_idx`=1.
3. Override asserted exactly on the hold-expiry tick of idx 0.
   - `color_idx` stays 0 and the override target is taken.
   - After the override hold, `color_idx`=1.
4. `enable`=0 for 37 cycles mid-fade.
   - Duty, `pre_cnt` and state are unchanged. `ovr_ready`=0 and `ovr_valid` is ignored.
   - On re-enable, the tick phase resumes where it stopped.
5. `rst_n` pulsed low mid-fade at `duty_g`=77.
   - All outputs go to reset values asynchronously, before the next clock edge.
   - The sequence restarts from black toward FF0000.
6. Palette wrap.
   - After idx 7 (black) has been held, `color_idx`=0 and the fade toward FF0000 begins.
